// File: rtl/l1_bus_pkg.sv
// Shared definitions for the L1 bus responder and the L1 cache that drives it.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package l1_bus_pkg;

  localparam int ADDR_WIDTH_DEF = 24;
  localparam int LINE_WID_DEF   = 7;
  localparam int TIMEOUT_DEF    = 255;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LINE = 3'd1,
    LWR  = 3'd2,
    SRD  = 3'd3,
    SWR  = 3'd4,
    FIN  = 3'd5,
    ERR  = 3'd6
  } bus_state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_LINE  = 2'd1,
    REQ_READ  = 2'd2,
    REQ_WRITE = 2'd3
  } req_kind_t;

  // Fixed priority: line fill beats single read beats write-through.
  function automatic req_kind_t pick_req(input logic line_req,
                                         input logic rd_req,
                                         input logic wr_req);
    if (line_req)    return REQ_LINE;
    else if (rd_req) return REQ_READ;
    else if (wr_req) return REQ_WRITE;
    else             return REQ_NONE;
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Beat watchdog: counts request cycles without an ack and flags expiry.
// Latency: expired is combinational, asserted in the TIMEOUT-th unacked cycle.
// Backpressure: none; the FSM drops the request in response to expired.
// Ports: clk, rst (async active-low), en (request pending, no ack),
//        clr (no beat in flight), expired (this cycle is the last allowed).
module bus_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= cnt + 8'd1;
  end

  // Firing while cnt still reads TIMEOUT-1 keeps mem_req high for exactly
  // TIMEOUT cycles before the beat is abandoned.
  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/l1_bus_responder.sv
// L1 refill/uncached responder: walks a line byte by byte over a req/ack port.
// Latency: 1 cycle request to mem_req; L+2 cycles per beat for ack latency L.
// Backpressure: each beat holds mem_req until mem_ack or watchdog expiry.
// Ports: cache side read_line_req/read_req/write_through_req, bus_pa, bus_wdata,
//        bus_rdata, addr_count, line_write, bus_trans_finish, bus_error;
//        memory side mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata/mem_err.
module l1_bus_responder
  import l1_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_WID   = LINE_WID_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_line_req,
  input  logic                  read_req,
  input  logic                  write_through_req,
  input  logic [ADDR_WIDTH-1:0] bus_pa,
  input  logic [7:0]            bus_wdata,
  output logic [7:0]            bus_rdata,
  output logic [LINE_WID:0]     addr_count,
  output logic                  line_write,
  output logic                  bus_trans_finish,
  output logic                  bus_error,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_err
);

  localparam int CW = LINE_WID + 1;

  bus_state_t            state, state_nx;
  logic [ADDR_WIDTH-1:0] base, base_nx;
  logic                  base_ld;
  logic                  rdata_ld;
  logic                  cnt_inc;
  logic                  tmo_expired;

  // Outputs decode straight from registered state, so an asynchronous reset
  // removes mem_req and every pulse in the same instant.
  assign mem_req          = (state == LINE) || (state == SRD) || (state == SWR);
  assign mem_we           = (state == SWR);
  assign mem_wdata        = (state == SWR) ? bus_wdata : 8'd0;
  assign mem_addr         = (state == LINE) ? {base[ADDR_WIDTH-1:CW], addr_count} : base;
  assign line_write       = (state == LWR);
  assign bus_trans_finish = (state == FIN);
  assign bus_error        = (state == ERR);

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .en      (mem_req & ~mem_ack),
    .clr     (~mem_req),
    .expired (tmo_expired)
  );

  always_comb begin
    state_nx = state;
    base_nx  = bus_pa;
    base_ld  = 1'b0;
    rdata_ld = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      IDLE: begin
        base_ld = 1'b1;
        case (pick_req(read_line_req, read_req, write_through_req))
          REQ_LINE: begin
            state_nx = LINE;
            base_nx  = {bus_pa[ADDR_WIDTH-1:CW], {CW{1'b0}}};
          end
          REQ_READ:  state_nx = SRD;
          REQ_WRITE: state_nx = SWR;
          default:   base_ld = 1'b0;
        endcase
      end
      LINE: begin
        if (mem_ack) begin
          if (mem_err) state_nx = ERR;
          else begin
            rdata_ld = 1'b1;
            state_nx = LWR;
          end
        end else if (tmo_expired) begin
          state_nx = ERR;
        end
      end
      LWR: begin
        // The byte just written always lands; a withdrawn fill stops here.
        cnt_inc = 1'b1;
        if (!read_line_req)   state_nx = IDLE;
        else if (&addr_count) state_nx = FIN;
        else                  state_nx = LINE;
      end
      SRD: begin
        if (mem_ack) begin
          if (mem_err) state_nx = ERR;
          else begin
            rdata_ld = 1'b1;
            state_nx = read_req ? FIN : IDLE;
          end
        end else if (tmo_expired) begin
          state_nx = ERR;
        end
      end
      SWR: begin
        if (mem_ack) begin
          if (mem_err) state_nx = ERR;
          else         state_nx = write_through_req ? FIN : IDLE;
        end else if (tmo_expired) begin
          state_nx = ERR;
        end
      end
      FIN:     state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      base       <= '0;
      addr_count <= '0;
      bus_rdata  <= 8'd0;
    end else begin
      state <= state_nx;
      if (base_ld)  base <= base_nx;
      if (state == IDLE) addr_count <= '0;
      else if (cnt_inc)  addr_count <= addr_count + CW'(1);
      if (rdata_ld) bus_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_l1_bus_responder.sv
// Randomised scoreboard bench for l1_bus_responder with a behavioural memory.
// Latency: n/a.
// Backpressure: the memory model inserts a per-transaction ack latency.
module tb_l1_bus_responder;

  localparam int AW = 24;
  localparam int LW = 7;
  localparam int TO = 255;

  localparam int EV_WR  = 0;
  localparam int EV_FIN = 1;
  localparam int EV_ERR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          read_line_req = 1'b0;
  logic          read_req = 1'b0;
  logic          write_through_req = 1'b0;
  logic [AW-1:0] bus_pa = '0;
  logic [7:0]    bus_wdata = 8'd0;
  logic [7:0]    bus_rdata;
  logic [LW:0]   addr_count;
  logic          line_write;
  logic          bus_trans_finish;
  logic          bus_error;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_rdata = 8'd0;
  logic          mem_err = 1'b0;

  always #5 clk = ~clk;

  l1_bus_responder #(
    .ADDR_WIDTH (AW),
    .LINE_WID   (LW),
    .TIMEOUT    (TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .read_line_req     (read_line_req),
    .read_req          (read_req),
    .write_through_req (write_through_req),
    .bus_pa            (bus_pa),
    .bus_wdata         (bus_wdata),
    .bus_rdata         (bus_rdata),
    .addr_count        (addr_count),
    .line_write        (line_write),
    .bus_trans_finish  (bus_trans_finish),
    .bus_error         (bus_error),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata),
    .mem_err           (mem_err)
  );

  typedef struct {
    int         kind;
    int         idx;
    logic [7:0] data;
  } ev_t;

  ev_t        sb[$];
  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;
  int         done_cnt = 0;
  int         txn_id = 0;
  int         cur_kind = 0;
  logic [23:0] cur_pa = '0;
  logic [7:0] cur_wdata = 8'd0;
  int         cur_lat = 0;
  int         err_at = -1;
  logic [7:0] model_rd = 8'd0;

  function automatic logic [7:0] mem_val(input logic [23:0] a);
    return a[7:0] ^ a[23:16] ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] ored;
    ored = 32'(bus_rdata) | 32'(addr_count) | 32'(line_write) | 32'(bus_trans_finish)
         | 32'(bus_error) | 32'(mem_req) | 32'(mem_we) | 32'(mem_addr) | 32'(mem_wdata);
    check(tag, ored, 32'd0);
  endtask

  // Reference: what the cache side should see for one transaction.
  // kind 0 = line fill, 1 = single read, 2 = write-through.
  task automatic model_push(input int kind, input logic [23:0] pa, input int lat,
                            input int eat, input int limit);
    ev_t e;
    logic [23:0] a;
    for (int i = 0; i < ((kind == 0) ? 256 : 1); i++) begin
      if (i == limit) return;
      if (lat >= TO || i == eat) begin
        e = '{EV_ERR, 0, model_rd};
        sb.push_back(e);
        return;
      end
      a = (kind == 0) ? {pa[23:8], 8'(i)} : pa;
      if (kind != 2) model_rd = mem_val(a);
      if (kind == 0) begin
        e = '{EV_WR, i, model_rd};
        sb.push_back(e);
      end
    end
    e = '{EV_FIN, 0, model_rd};
    sb.push_back(e);
  endtask

  // Memory model: acks after cur_lat waiting cycles, checks the beat contents.
  initial begin
    int wait_cnt;
    int beat_no;
    int seen_id;
    logic [23:0] exp_addr;
    wait_cnt = 0;
    beat_no  = 0;
    seen_id  = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_err = 1'b0;
      if (txn_id != seen_id) begin
        seen_id = txn_id;
        beat_no = 0;
      end
      if (!rst || !mem_req) begin
        wait_cnt = 0;
      end else if (wait_cnt >= cur_lat) begin
        exp_addr = (cur_kind == 0) ? {cur_pa[23:8], 8'(beat_no)} : cur_pa;
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        check("mem_we", 32'(mem_we), 32'(cur_kind == 2));
        if (cur_kind == 2) check("mem_wdata", 32'(mem_wdata), 32'(cur_wdata));
        mem_ack   = 1'b1;
        mem_err   = (beat_no == err_at);
        mem_rdata = mem_err ? 8'hEE : mem_val(mem_addr);
        beat_no++;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Monitor: every cache-side pulse must match the head of the scoreboard.
  initial begin
    ev_t e;
    int n;
    int act;
    forever begin
      @(negedge clk);
      if (rst) begin
        n = int'(line_write) + int'(bus_trans_finish) + int'(bus_error);
        if (n > 1) check("one_pulse", 32'(n), 32'd1);
        if (n != 0) begin
          act = line_write ? EV_WR : (bus_trans_finish ? EV_FIN : EV_ERR);
          if (line_write) wr_cnt++;
          else            done_cnt++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got event kind %0d, required none", act);
          end else begin
            e = sb.pop_front();
            check("event_kind", 32'(act), 32'(e.kind));
            if (e.kind == EV_WR) check("addr_count", 32'(addr_count), 32'(e.idx));
            check("bus_rdata", 32'(bus_rdata), 32'(e.data));
          end
        end
      end
    end
  end

  // mode 0: run to completion; 1: withdraw after stop_n writes; 2: reset after stop_n writes.
  task automatic run_txn(input int kind, input logic [23:0] pa, input logic [7:0] wd,
                         input int lat, input int eat, input int mode, input int stop_n);
    int start_done, start_wr, cyc, req_cyc, budget;
    bit hit;
    model_push(kind, pa, lat, eat, (mode == 0) ? 256 : stop_n);
    cur_kind  = kind;
    cur_pa    = pa;
    cur_wdata = wd;
    cur_lat   = lat;
    err_at    = eat;
    txn_id++;
    @(negedge clk);
    #1;
    bus_pa            = pa;
    bus_wdata         = wd;
    read_line_req     = (kind == 0);
    read_req          = (kind == 1);
    write_through_req = (kind == 2);
    start_done = done_cnt;
    start_wr   = wr_cnt;
    cyc        = 0;
    req_cyc    = 0;
    hit        = 1'b0;
    budget     = (lat >= TO) ? TO + 50 : 256 * (lat + 2) + 50;
    while (!hit && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
      if (mem_req) req_cyc++;
      if (mode == 0) hit = (done_cnt != start_done);
      else           hit = (wr_cnt - start_wr == stop_n);
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: got no completion after %0d cycles, required one", budget);
    end else if (mode == 2) begin
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_all_zero("reset_midline_outputs");
      model_rd = 8'd0;
    end
    read_line_req     = 1'b0;
    read_req          = 1'b0;
    write_through_req = 1'b0;
    if (hit && mode == 0) begin
      if (lat >= TO)    check("timeout_req_cycles", 32'(req_cyc), 32'(TO));
      else if (eat < 0) check("finish_latency", 32'(cyc),
                              32'((kind == 0) ? 256 * (lat + 2) + 1 : lat + 2));
    end
    repeat (4) @(negedge clk);
    #1;
    if (mode == 2) rst = 1'b1;
    check("mem_req_quiet", 32'(mem_req), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int k, eat, lat;
    logic [23:0] pa;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    #1;
    rst = 1'b1;

    run_txn(0, 24'h012345, 8'h00, 1, -1, 0, 0);
    run_txn(1, 24'h00ABCD, 8'h00, 3, -1, 0, 0);
    run_txn(2, 24'h000010, 8'h3C, 0, -1, 0, 0);
    run_txn(0, 24'h4F00A7, 8'h00, 2, 17, 0, 0);
    run_txn(0, 24'h777777, 8'h00, 100000, -1, 0, 0);
    run_txn(0, 24'h1234FF, 8'h00, 0, -1, 1, 40);
    run_txn(0, 24'hC0FFEE, 8'h00, 1, -1, 2, 100);
    run_txn(0, 24'h0A0B0C, 8'h00, 0, -1, 0, 0);
    run_txn(1, 24'h00BEEF, 8'h00, 1, 0, 0, 0);

    for (int t = 0; t < 8; t++) begin
      k   = int'($urandom_range(0, 2));
      pa  = 24'($urandom);
      lat = int'($urandom_range(0, 3));
      eat = -1;
      if ($urandom_range(0, 2) == 0) eat = (k == 0) ? int'($urandom_range(0, 255)) : 0;
      run_txn(k, pa, 8'($urandom), lat, eat, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
